// File: rtl/streamer_pkg.sv
// rtl/streamer_pkg.sv - shared state encodings and keep helper for the multi-slot streamer
package streamer_pkg;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_STORE = 4'd1;
    localparam logic [3:0] ST_DRAIN = 4'd2;
    localparam logic [3:0] ST_LOAD  = 4'd3;

    localparam int MAX_KEEP_WIDTH = 128;

    // All-ones keep mask of keep_width bits, zero-padded to MAX_KEEP_WIDTH.
    function automatic logic [MAX_KEEP_WIDTH-1:0] full_keep(input int keep_width);
        logic [MAX_KEEP_WIDTH-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_KEEP_WIDTH; i++) begin
            if (i < keep_width) k[i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/multi_slot_streamer_if.sv
// rtl/multi_slot_streamer_if.sv - AXI-Stream style bundle with master/slave views
interface multi_slot_streamer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/streamer_slot_ram.sv
// rtl/streamer_slot_ram.sv - simple dual-port slot RAM with a registered read port
module streamer_slot_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/multi_slot_streamer.sv
// rtl/multi_slot_streamer.sv - multi-slot AXI-Stream capture and replay engine
module multi_slot_streamer
    import streamer_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int SLOT_IDX_WIDTH   = 2,
    parameter int SLOT_DEPTH_WIDTH = 8,
    parameter int STATE_BIT_WIDTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    multi_slot_streamer_if.slave         s_axi,
    multi_slot_streamer_if.master        m_axi,
    input  logic [SLOT_IDX_WIDTH-1:0]    storeSlot,
    input  logic [SLOT_IDX_WIDTH-1:0]    loadSlot,
    input  logic                         storeReset,
    input  logic                         loadReset,
    input  logic                         storeInit,
    input  logic                         loadInit,
    output logic                         finStore,
    output logic                         finLoad,
    output logic                         errOverflow,
    output logic [STATE_BIT_WIDTH-1:0]   dbg_state,
    output logic [SLOT_DEPTH_WIDTH:0]    dbg_store_words,
    output logic [SLOT_DEPTH_WIDTH:0]    dbg_load_words
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int NUM_SLOTS  = 1 << SLOT_IDX_WIDTH;
    localparam int CW         = SLOT_DEPTH_WIDTH + 1;
    localparam int AW         = SLOT_IDX_WIDTH + SLOT_DEPTH_WIDTH;

    localparam logic [STATE_BIT_WIDTH-1:0] IDLE  = STATE_BIT_WIDTH'(ST_IDLE);
    localparam logic [STATE_BIT_WIDTH-1:0] STORE = STATE_BIT_WIDTH'(ST_STORE);
    localparam logic [STATE_BIT_WIDTH-1:0] DRAIN = STATE_BIT_WIDTH'(ST_DRAIN);
    localparam logic [STATE_BIT_WIDTH-1:0] LOAD  = STATE_BIT_WIDTH'(ST_LOAD);

    localparam logic [MAX_KEEP_WIDTH-1:0] FULL_KEEP_ALL = full_keep(KEEP_WIDTH);
    localparam logic [KEEP_WIDTH-1:0]     FULL_KEEP     = FULL_KEEP_ALL[KEEP_WIDTH-1:0];
    localparam logic [CW-1:0]             FULL_COUNT    = {1'b1, {SLOT_DEPTH_WIDTH{1'b0}}};
    localparam logic [CW-1:0]             ONE           = CW'(1);

    logic [STATE_BIT_WIDTH-1:0] state;
    logic [CW-1:0]              count     [NUM_SLOTS];
    logic [KEEP_WIDTH-1:0]      last_keep [NUM_SLOTS];
    logic [SLOT_IDX_WIDTH-1:0]  st_slot, ld_slot;
    logic [CW-1:0]              load_words;

    logic [CW-1:0]              rd_ptr;
    logic                       rd_inflight, rd_last_q;
    logic                       out_valid, out_last;
    logic [DATA_WIDTH-1:0]      out_data;
    logic [KEEP_WIDTH-1:0]      out_keep;
    logic                       skid_valid, skid_last;
    logic [DATA_WIDTH-1:0]      skid_data;
    logic [DATA_WIDTH-1:0]      ram_rdata;

    logic [CW-1:0] st_count, ld_count;
    logic          beat, overflow_beat, pop, issue, issue_last, out_free;
    logic [1:0]    occ;

    assign st_count      = count[st_slot];
    assign ld_count      = count[ld_slot];
    assign s_axi.tready  = (state == STORE) || (state == DRAIN);
    assign beat          = s_axi.tvalid && s_axi.tready;
    assign overflow_beat = (st_count == FULL_COUNT);
    assign pop           = out_valid && m_axi.tready;
    assign out_free      = !out_valid || pop;

    // Reads are issued only when the output register, skid and in-flight read
    // can still absorb the result after this cycle's pop.
    assign occ        = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_inflight};
    assign issue      = (state == LOAD) && (rd_ptr != ld_count) && ((occ - {1'b0, pop}) < 2'd2);
    assign issue_last = (rd_ptr == ld_count - ONE);

    assign m_axi.tdata  = out_data;
    assign m_axi.tkeep  = out_keep;
    assign m_axi.tvalid = out_valid;
    assign m_axi.tlast  = out_last;

    assign dbg_state       = state;
    assign dbg_store_words = count[storeSlot];
    assign dbg_load_words  = load_words;

    streamer_slot_ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    ((state == STORE) && beat && !overflow_beat),
        .waddr ({st_slot, st_count[SLOT_DEPTH_WIDTH-1:0]}),
        .wdata (s_axi.tdata),
        .re    (issue),
        .raddr ({ld_slot, rd_ptr[SLOT_DEPTH_WIDTH-1:0]}),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                count[i]     <= '0;
                last_keep[i] <= '0;
            end
            st_slot     <= '0;
            ld_slot     <= '0;
            load_words  <= '0;
            finStore    <= 1'b0;
            finLoad     <= 1'b0;
            errOverflow <= 1'b0;
            rd_ptr      <= '0;
            rd_inflight <= 1'b0;
            rd_last_q   <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            out_keep    <= '0;
            skid_valid  <= 1'b0;
            skid_last   <= 1'b0;
            skid_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (storeReset) begin
                        count[storeSlot]     <= '0;
                        last_keep[storeSlot] <= '0;
                        finStore             <= 1'b0;
                        errOverflow          <= 1'b0;
                    end else if (loadReset) begin
                        finLoad    <= 1'b0;
                        load_words <= '0;
                    end else if (storeInit) begin
                        st_slot          <= storeSlot;
                        count[storeSlot] <= '0;
                        finStore         <= 1'b0;
                        state            <= STORE;
                    end else if (loadInit) begin
                        ld_slot    <= loadSlot;
                        load_words <= '0;
                        rd_ptr     <= '0;
                        if (count[loadSlot] == '0) begin
                            finLoad <= 1'b1;
                        end else begin
                            finLoad <= 1'b0;
                            state   <= LOAD;
                        end
                    end
                end
                STORE: begin
                    if (beat) begin
                        if (overflow_beat) begin
                            errOverflow <= 1'b1;
                            if (s_axi.tlast) begin
                                finStore <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                state <= DRAIN;
                            end
                        end else begin
                            count[st_slot] <= st_count + ONE;
                            if (s_axi.tlast) begin
                                last_keep[st_slot] <= s_axi.tkeep;
                                finStore           <= 1'b1;
                                state              <= IDLE;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (beat && s_axi.tlast) begin
                        finStore <= 1'b1;
                        state    <= IDLE;
                    end
                end
                LOAD: begin
                    if (pop) load_words <= load_words + ONE;
                    if (pop && out_last) begin
                        finLoad <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue) rd_ptr <= rd_ptr + ONE;
            rd_inflight <= issue;
            rd_last_q   <= issue_last;

            // The skid always holds the oldest pending word, so it refills the
            // output ahead of any read that lands this cycle.
            if (out_free) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                    out_last  <= skid_last;
                    out_keep  <= skid_last ? last_keep[ld_slot] : FULL_KEEP;
                end else if (rd_inflight) begin
                    out_valid <= 1'b1;
                    out_data  <= ram_rdata;
                    out_last  <= rd_last_q;
                    out_keep  <= rd_last_q ? last_keep[ld_slot] : FULL_KEEP;
                end else begin
                    out_valid <= 1'b0;
                end
            end

            if (skid_valid && out_free) begin
                skid_valid <= rd_inflight;
                skid_data  <= ram_rdata;
                skid_last  <= rd_last_q;
            end else if (!skid_valid && rd_inflight && !out_free) begin
                skid_valid <= 1'b1;
                skid_data  <= ram_rdata;
                skid_last  <= rd_last_q;
            end
        end
    end
endmodule
